// File: rtl/pe_net_seq_if.sv
// Stream-side handshake bundle feeding the PE-array sequencer: the weight
// stream and the pixel stream, each a valid/ready pair with a row-wide payload.
interface pe_net_seq_if #(
   parameter int ROW_SIZE = 4,
   parameter int N        = 4,
   parameter int M        = 2
);
   logic                  w_s_valid;
   logic                  w_s_ready;
   logic [ROW_SIZE*M-1:0] w_s_data;
   logic                  px_valid;
   logic                  px_ready;
   logic [ROW_SIZE*N-1:0] px_data;

   modport master (
      output w_s_valid, w_s_data, px_valid, px_data,
      input  w_s_ready, px_ready
   );

   modport slave (
      input  w_s_valid, w_s_data, px_valid, px_data,
      output w_s_ready, px_ready
   );
endinterface

// File: rtl/pe_net_seq.sv
// PE-array sequencer: loads kernel weights into the w_conf chain, issues the
// control strobe, streams a LINES x PIX frame into the rows, then drains.
//
// state  | meaning
// IDLE   | waiting for cfg_start; config outputs held at zero
// WLOAD  | accepting KERNEL*KERNEL weight beats into the w_conf chain
// CCONF  | single cycle; cntl_conf issued, config outputs already live
// STREAM | accepting LINES*PIX pixel beats into the array rows
// DRAIN  | DRAIN-cycle wait for the array pipeline, then done pulse
module pe_net_seq #(
   parameter int ROW_SIZE = 4,
   parameter int N        = 4,
   parameter int M        = 2,
   parameter int CL_IN    = 4,
   parameter int CL1      = 2,
   parameter int KERNEL   = 3,
   parameter int LINES    = 16,
   parameter int PIX      = 16,
   parameter int DRAIN    = 8,
   parameter int CW       = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_start,
   input  logic                      abort,
   input  logic [ROW_SIZE-1:0]       cfg_row_en,
   input  logic [ROW_SIZE*CL_IN-1:0] cfg_d_ch,
   input  logic [ROW_SIZE*CL_IN-1:0] cfg_bp_ch,
   input  logic [ROW_SIZE*CL1-1:0]   cfg_bp_src,
   pe_net_seq_if.slave               strm,
   output logic                      w_conf,
   output logic [ROW_SIZE*M-1:0]     w_in,
   output logic                      cntl_conf,
   output logic [ROW_SIZE*CL_IN-1:0] d_ch_in,
   output logic [ROW_SIZE*CL_IN-1:0] bp_ch_in,
   output logic [ROW_SIZE*CL1-1:0]   bp_src_in,
   output logic [ROW_SIZE*N-1:0]     d_in,
   output logic [ROW_SIZE-1:0]       en_in,
   input  logic [ROW_SIZE-1:0]       arr_en_out,
   output logic                      busy,
   output logic                      line_end,
   output logic                      done,
   output logic [CW-1:0]             res_cnt
);
   localparam int WBEATS = KERNEL * KERNEL;
   localparam int WCW    = $clog2(WBEATS + 1);
   localparam int PCW    = $clog2(PIX + 1);
   localparam int LCW    = $clog2(LINES + 1);
   localparam int DCW    = $clog2(DRAIN + 1);
   localparam logic [WCW-1:0] W_LAST = WCW'(WBEATS - 1);
   localparam logic [PCW-1:0] P_LAST = PCW'(PIX - 1);
   localparam logic [LCW-1:0] L_LAST = LCW'(LINES - 1);
   localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WLOAD, S_CCONF, S_STREAM, S_DRAIN
   } state_t;

   state_t state_q, state_d;

   logic [WCW-1:0] wcnt;
   logic [PCW-1:0] pix_cnt;
   logic [LCW-1:0] line_cnt;
   logic [DCW-1:0] dcnt;

   logic [ROW_SIZE-1:0]       sh_row_en;
   logic [ROW_SIZE*CL_IN-1:0] sh_d_ch;
   logic [ROW_SIZE*CL_IN-1:0] sh_bp_ch;
   logic [ROW_SIZE*CL1-1:0]   sh_bp_src;

   logic w_acc, px_acc, w_last, px_last, pix_wrap, counting;

   // Only row 0 output enables feed the result counter; other rows are ignored.
   logic unused_arr;
   assign unused_arr = ^arr_en_out;

   assign strm.w_s_ready = (state_q == S_WLOAD);
   assign strm.px_ready  = (state_q == S_STREAM);
   assign busy           = (state_q != S_IDLE);

   assign w_acc    = strm.w_s_valid && (state_q == S_WLOAD);
   assign px_acc   = strm.px_valid  && (state_q == S_STREAM);
   assign w_last   = (wcnt == W_LAST);
   assign pix_wrap = (pix_cnt == P_LAST);
   assign px_last  = pix_wrap && (line_cnt == L_LAST);
   assign counting = (state_q == S_STREAM) || (state_q == S_DRAIN);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state decode; abort overrides every transition, including start.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (cfg_start) state_d = S_WLOAD;
         S_WLOAD:  if (w_acc && w_last) state_d = S_CCONF;
         S_CCONF:  state_d = S_STREAM;
         S_STREAM: if (px_acc && px_last) state_d = S_DRAIN;
         S_DRAIN:  if (dcnt == '0) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   // Datapath: shadow config, beat/pixel counters, drain timer and array outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt      <= '0;
         pix_cnt   <= '0;
         line_cnt  <= '0;
         dcnt      <= '0;
         sh_row_en <= '0;
         sh_d_ch   <= '0;
         sh_bp_ch  <= '0;
         sh_bp_src <= '0;
         w_conf    <= 1'b0;
         w_in      <= '0;
         cntl_conf <= 1'b0;
         d_ch_in   <= '0;
         bp_ch_in  <= '0;
         bp_src_in <= '0;
         d_in      <= '0;
         en_in     <= '0;
         line_end  <= 1'b0;
         done      <= 1'b0;
         res_cnt   <= '0;
      end else begin
         w_conf    <= 1'b0;
         cntl_conf <= 1'b0;
         en_in     <= '0;
         line_end  <= 1'b0;
         done      <= 1'b0;
         if (!abort) begin
            case (state_q)
               S_IDLE: if (cfg_start) begin
                  sh_row_en <= cfg_row_en;
                  sh_d_ch   <= cfg_d_ch;
                  sh_bp_ch  <= cfg_bp_ch;
                  sh_bp_src <= cfg_bp_src;
                  res_cnt   <= '0;
                  wcnt      <= '0;
                  pix_cnt   <= '0;
                  line_cnt  <= '0;
               end
               S_WLOAD: if (w_acc) begin
                  w_conf <= 1'b1;
                  w_in   <= strm.w_s_data;
                  wcnt   <= wcnt + WCW'(1);
                  // Config goes live together with the CCONF state.
                  if (w_last) begin
                     d_ch_in   <= sh_d_ch;
                     bp_ch_in  <= sh_bp_ch;
                     bp_src_in <= sh_bp_src;
                  end
               end
               S_CCONF: cntl_conf <= 1'b1;
               S_STREAM: if (px_acc) begin
                  d_in     <= strm.px_data;
                  en_in    <= sh_row_en;
                  line_end <= pix_wrap;
                  if (pix_wrap) begin
                     pix_cnt  <= '0;
                     line_cnt <= line_cnt + LCW'(1);
                  end else begin
                     pix_cnt <= pix_cnt + PCW'(1);
                  end
                  if (px_last) dcnt <= D_LAST;
               end
               S_DRAIN: begin
                  if (dcnt == '0) done <= 1'b1;
                  else            dcnt <= dcnt - DCW'(1);
               end
               default: ;
            endcase
         end
         if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
            d_ch_in   <= '0;
            bp_ch_in  <= '0;
            bp_src_in <= '0;
         end
         if (counting && arr_en_out[0] && (res_cnt != {CW{1'b1}}))
            res_cnt <= res_cnt + CW'(1);
      end
   end
endmodule

// File: tb/tb_pe_net_seq.sv
// Bench for pe_net_seq: a phase-level model of the sequencer predicts every
// output each cycle from randomized and directed stimulus.
module tb_pe_net_seq;
   localparam int ROW_SIZE = 4;
   localparam int N        = 4;
   localparam int M        = 2;
   localparam int CL_IN    = 4;
   localparam int CL1      = 2;
   localparam int KERNEL   = 3;
   localparam int LINES    = 2;
   localparam int PIX      = 3;
   localparam int DRAIN    = 5;
   localparam int CW       = 3;
   localparam int KK       = KERNEL * KERNEL;
   localparam int NPIX     = LINES * PIX;
   localparam int GUARD    = 400;
   localparam int WCH      = ROW_SIZE * CL_IN;
   localparam int WSRC     = ROW_SIZE * CL1;
   localparam int WW       = ROW_SIZE * M;
   localparam int WD       = ROW_SIZE * N;

   typedef enum int {P_IDLE, P_WLOAD, P_CCONF, P_STREAM, P_DRAIN} phase_t;

   logic clk = 1'b0;
   logic rst;
   logic cfg_start, abort;
   logic [ROW_SIZE-1:0] cfg_row_en;
   logic [WCH-1:0]      cfg_d_ch, cfg_bp_ch;
   logic [WSRC-1:0]     cfg_bp_src;
   logic                w_conf, cntl_conf, busy, line_end, done;
   logic [WW-1:0]       w_in;
   logic [WCH-1:0]      d_ch_in, bp_ch_in;
   logic [WSRC-1:0]     bp_src_in;
   logic [WD-1:0]       d_in;
   logic [ROW_SIZE-1:0] en_in, arr_en_out;
   logic [CW-1:0]       res_cnt;

   pe_net_seq_if #(.ROW_SIZE(ROW_SIZE), .N(N), .M(M)) bus ();

   pe_net_seq #(
      .ROW_SIZE(ROW_SIZE), .N(N), .M(M), .CL_IN(CL_IN), .CL1(CL1),
      .KERNEL(KERNEL), .LINES(LINES), .PIX(PIX), .DRAIN(DRAIN), .CW(CW)
   ) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .abort(abort),
      .cfg_row_en(cfg_row_en), .cfg_d_ch(cfg_d_ch), .cfg_bp_ch(cfg_bp_ch),
      .cfg_bp_src(cfg_bp_src), .strm(bus), .w_conf(w_conf), .w_in(w_in),
      .cntl_conf(cntl_conf), .d_ch_in(d_ch_in), .bp_ch_in(bp_ch_in),
      .bp_src_in(bp_src_in), .d_in(d_in), .en_in(en_in),
      .arr_en_out(arr_en_out), .busy(busy), .line_end(line_end),
      .done(done), .res_cnt(res_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   phase_t              ph = P_IDLE;
   int                  wn, pn, dleft;
   logic [CW-1:0]       exp_res;
   logic [ROW_SIZE-1:0] m_row_en;
   logic [WCH-1:0]      m_d_ch, m_bp_ch;
   logic [WSRC-1:0]     m_bp_src;
   logic [WW-1:0]       last_w;
   logic [WD-1:0]       last_d;
   logic                exp_wconf, exp_cc, exp_le, exp_done;
   logic [ROW_SIZE-1:0] exp_en;
   int                  n_wconf, n_cc, n_le, n_done;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      ph = P_IDLE; wn = 0; pn = 0; dleft = 0;
      exp_res = '0; last_w = '0; last_d = '0;
      m_row_en = '0; m_d_ch = '0; m_bp_ch = '0; m_bp_src = '0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_w_conf"}, w_conf, 0);
      chk({tag, "_w_in"}, w_in, 0);
      chk({tag, "_cntl_conf"}, cntl_conf, 0);
      chk({tag, "_d_ch_in"}, d_ch_in, 0);
      chk({tag, "_bp_ch_in"}, bp_ch_in, 0);
      chk({tag, "_bp_src_in"}, bp_src_in, 0);
      chk({tag, "_d_in"}, d_in, 0);
      chk({tag, "_en_in"}, en_in, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_line_end"}, line_end, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_res_cnt"}, res_cnt, 0);
      chk({tag, "_w_s_ready"}, bus.w_s_ready, 0);
      chk({tag, "_px_ready"}, bus.px_ready, 0);
   endtask

   // One clock: called at a falling edge with inputs already applied.
   task automatic step();
      phase_t nph;
      logic   live;
      chk("w_s_ready", bus.w_s_ready, ph == P_WLOAD);
      chk("px_ready", bus.px_ready, ph == P_STREAM);
      nph = ph;
      exp_wconf = 0; exp_cc = 0; exp_le = 0; exp_done = 0; exp_en = '0;
      if ((ph == P_STREAM || ph == P_DRAIN) && arr_en_out[0] && exp_res != '1)
         exp_res = exp_res + 1'b1;
      if (abort) nph = P_IDLE;
      else case (ph)
         P_IDLE: if (cfg_start) begin
            nph = P_WLOAD; wn = 0; pn = 0; exp_res = '0;
            m_row_en = cfg_row_en; m_d_ch = cfg_d_ch;
            m_bp_ch = cfg_bp_ch; m_bp_src = cfg_bp_src;
         end
         P_WLOAD: if (bus.w_s_valid) begin
            exp_wconf = 1; last_w = bus.w_s_data; wn++;
            if (wn == KK) nph = P_CCONF;
         end
         P_CCONF: begin exp_cc = 1; nph = P_STREAM; end
         P_STREAM: if (bus.px_valid) begin
            exp_en = m_row_en; last_d = bus.px_data;
            exp_le = (pn % PIX == PIX - 1); pn++;
            if (pn == NPIX) begin nph = P_DRAIN; dleft = DRAIN; end
         end
         P_DRAIN: begin
            dleft--;
            if (dleft == 0) begin nph = P_IDLE; exp_done = 1; end
         end
         default: nph = P_IDLE;
      endcase
      ph = nph;
      @(posedge clk);
      @(negedge clk);
      live = (ph == P_CCONF || ph == P_STREAM || ph == P_DRAIN);
      chk("w_conf", w_conf, exp_wconf);
      chk("w_in", w_in, last_w);
      chk("cntl_conf", cntl_conf, exp_cc);
      chk("en_in", en_in, exp_en);
      chk("d_in", d_in, last_d);
      chk("line_end", line_end, exp_le);
      chk("done", done, exp_done);
      chk("busy", busy, ph != P_IDLE);
      chk("res_cnt", res_cnt, exp_res);
      chk("d_ch_in", d_ch_in, live ? m_d_ch : '0);
      chk("bp_ch_in", bp_ch_in, live ? m_bp_ch : '0);
      chk("bp_src_in", bp_src_in, live ? m_bp_src : '0);
      n_wconf += int'(w_conf); n_cc += int'(cntl_conf);
      n_le += int'(line_end); n_done += int'(done);
   endtask

   task automatic rand_cfg();
      cfg_row_en = ROW_SIZE'($urandom);
      cfg_d_ch   = WCH'($urandom);
      cfg_bp_ch  = WCH'($urandom);
      cfg_bp_src = WSRC'($urandom);
   endtask

   task automatic start_frame(input bit directed);
      rand_cfg();
      if (directed) cfg_row_en = 4'b1011;
      n_wconf = 0; n_cc = 0; n_le = 0; n_done = 0;
      bus.w_s_valid = 0; bus.px_valid = 0; arr_en_out = '0;
      cfg_start = 1;
      step();
      cfg_start = 0;
   endtask

   task automatic run_frame(input bit directed, input int abort_beat);
      int guard;
      start_frame(directed);
      guard = 0;
      while (ph != P_IDLE && guard < GUARD) begin
         bus.w_s_valid = directed ? (guard % 2 == 0) : 1'($urandom);
         bus.w_s_data  = directed ? WW'(wn) : WW'($urandom);
         bus.px_valid  = directed ? 1'b1 : 1'($urandom);
         bus.px_data   = directed ? WD'(pn + 1) : WD'($urandom);
         arr_en_out    = directed ? {3'b000, ph == P_DRAIN} : ROW_SIZE'($urandom);
         if (!directed) begin
            cfg_start = ($urandom % 6 == 0);
            rand_cfg();
         end
         abort = (abort_beat >= 0 && ph == P_WLOAD && wn == abort_beat && bus.w_s_valid);
         step();
         abort = 0; cfg_start = 0;
         guard++;
      end
      chk("frame_in_budget", guard < GUARD, 1);
      bus.w_s_valid = 0; bus.px_valid = 0; arr_en_out = '0;
   endtask

   task automatic reset_mid_stream();
      int guard;
      start_frame(0);
      guard = 0;
      while (!(ph == P_STREAM && pn >= 2) && guard < GUARD) begin
         bus.w_s_valid = 1'($urandom); bus.w_s_data = WW'($urandom);
         bus.px_valid  = 1'($urandom); bus.px_data  = WD'($urandom);
         arr_en_out = ROW_SIZE'($urandom);
         step();
         guard++;
      end
      chk("mid_stream_reached", guard < GUARD, 1);
      bus.w_s_valid = 0; bus.px_valid = 0; arr_en_out = '0;
      rst = 0;
      #1;
      check_zero("async_rst");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      check_zero("held_rst");
      rst = 1;
      step();
      chk("px_ready_after_rst", bus.px_ready, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 0; cfg_start = 0; abort = 0; arr_en_out = '0;
      cfg_row_en = '0; cfg_d_ch = '0; cfg_bp_ch = '0; cfg_bp_src = '0;
      bus.w_s_valid = 0; bus.w_s_data = '0; bus.px_valid = 0; bus.px_data = '0;
      model_reset();
      n_wconf = 0; n_cc = 0; n_le = 0; n_done = 0;
      @(negedge clk);
      @(negedge clk);
      check_zero("reset");
      rst = 1;
      step();

      // directed frame: weights 0..8 on alternate cycles, pixels 1..6 on rows 1011
      run_frame(1, -1);
      chk("dir_w_pulses", n_wconf, KK);
      chk("dir_cntl_pulses", n_cc, 1);
      chk("dir_line_ends", n_le, LINES);
      chk("dir_done_pulses", n_done, 1);
      arr_en_out = 4'b0001;
      step();
      step();
      arr_en_out = '0;
      chk("res_cnt_5", res_cnt, 5);

      // abort on the 4th weight beat, then restart from beat 0
      run_frame(0, 3);
      repeat (4) step();
      chk("abort_w_pulses", n_wconf, 3);
      chk("abort_cntl_pulses", n_cc, 0);
      chk("abort_done_pulses", n_done, 0);
      run_frame(0, -1);
      chk("restart_w_pulses", n_wconf, KK);
      chk("restart_done_pulses", n_done, 1);

      // abort together with cfg_start in idle keeps the block idle
      rand_cfg();
      cfg_start = 1; abort = 1;
      step();
      cfg_start = 0; abort = 0;
      chk("abort_start_busy", busy, 0);

      reset_mid_stream();

      for (int f = 0; f < 8; f++) begin
         run_frame(0, -1);
         chk("rand_w_pulses", n_wconf, KK);
         chk("rand_cntl_pulses", n_cc, 1);
         chk("rand_line_ends", n_le, LINES);
         chk("rand_done_pulses", n_done, 1);
         repeat (2) step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
